ld_st_shift_ctrl: RTL and testbench

//  Sequencer for a WIDTH-bit load/shift register chain built from hold/shift cells.

---
 rtl/ld_st_pkg.sv | 15 +
 rtl/ld_st_shift_reg.sv | 48 ++++
 rtl/ld_st_shift_ctrl.sv | 163 ++++++++++++++++
 tb/tb_ld_st_shift_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ld_st_pkg.sv
// Shared encodings for the load/shift serializer.
// Parity build option: define LD_ST_SHIFT_PARITY_EN.
package ld_st_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam logic LS_HOLD  = 1'b0;
    localparam logic LS_SHIFT = 1'b1;

endpackage

// File: rtl/ld_st_shift_reg.sv
// WIDTH-bit chain of hold/shift cells with parallel load; sl_in enters at the MSB.
module ld_st_shift_reg
    import ld_st_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic             l_s,
    input  logic             sl_in,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Each cell picks load data, its left neighbour, or itself.
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
        logic shift_src;
        if (i == int'(WIDTH) - 1) begin : g_msb
            assign shift_src = sl_in;
        end else begin : g_mid
            assign shift_src = q_q[i+1];
        end

        always_comb begin
            q_d[i] = q_q[i];
            if (load) begin
                q_d[i] = d[i];
            end else if (l_s == LS_SHIFT) begin
                q_d[i] = shift_src;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/ld_st_shift_ctrl.sv
// Word-to-bit-serial sequencer driving an ld_st_shift_reg chain, LSB first.
// Define LD_ST_SHIFT_PARITY_EN to append an even-parity bit after each word.
module ld_st_shift_ctrl
    import ld_st_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4,
    parameter logic        FILL  = 1'b0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] din,
    input  logic             ser_ready,
    output logic             ser_valid,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load;
    logic             l_s;
    logic [WIDTH-1:0] sreg_q;
    logic             lsb_nxt;

    logic in_ready_q,  in_ready_d;
    logic ser_valid_q, ser_valid_d;
    logic ser_out_q,   ser_out_d;
    logic busy_q,      busy_d;
    logic done_q,      done_d;

`ifdef LD_ST_SHIFT_PARITY_EN
    logic par_q, par_d;
`endif

    ld_st_shift_reg #(
        .WIDTH (WIDTH)
    ) u_sreg (
        .clk   (clk),
        .clr   (clr),
        .load  (load),
        .l_s   (l_s),
        .sl_in (FILL),
        .d     (din),
        .q     (sreg_q)
    );

    // Only the two low cells are needed to predict the next serial bit.
    logic unused_sreg_hi;
    assign unused_sreg_hi = ^sreg_q;

    // Next-state, chain control and next-output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        l_s     = LS_HOLD;
`ifdef LD_ST_SHIFT_PARITY_EN
        par_d   = par_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
`ifdef LD_ST_SHIFT_PARITY_EN
                    par_d   = ^din;
`endif
                end
            end
            ST_SHIFT: begin
                if (ser_ready) begin
                    l_s   = LS_SHIFT;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
`ifdef LD_ST_SHIFT_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_DONE;
`endif
                    end
                end
            end
`ifdef LD_ST_SHIFT_PARITY_EN
            ST_PARITY: begin
                if (ser_ready) begin
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Bit 0 of the chain after this edge, so ser_out can be a flop.
        lsb_nxt = sreg_q[0];
        if (load) begin
            lsb_nxt = din[0];
        end else if (l_s == LS_SHIFT) begin
            lsb_nxt = sreg_q[1];
        end

        in_ready_d  = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
        ser_valid_d = (state_d == ST_SHIFT) || (state_d == ST_PARITY);
        ser_out_d   = 1'b0;
        if (state_d == ST_SHIFT) begin
            ser_out_d = lsb_nxt;
        end
`ifdef LD_ST_SHIFT_PARITY_EN
        if (state_d == ST_PARITY) begin
            ser_out_d = par_d;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            ser_valid_q <= 1'b0;
            ser_out_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            ser_valid_q <= ser_valid_d;
            ser_out_q   <= ser_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

`ifdef LD_ST_SHIFT_PARITY_EN
    always_ff @(posedge clk) begin
        if (clr) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

    assign in_ready  = in_ready_q;
    assign ser_valid = ser_valid_q;
    assign ser_out   = ser_out_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_ld_st_shift_ctrl.sv
// Directed bench for ld_st_shift_ctrl with a bit scoreboard; honours LD_ST_SHIFT_PARITY_EN.
module tb_ld_st_shift_ctrl;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 4;
`ifdef LD_ST_SHIFT_PARITY_EN
    localparam int PAR_EN = 1;
`else
    localparam int PAR_EN = 0;
`endif

    logic       clk = 1'b0;
    logic       clr;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] din;
    logic       ser_ready;
    logic       ser_valid;
    logic       ser_out;
    logic       busy;
    logic       done;

    int   errors = 0;
    int   checks = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    ld_st_shift_ctrl #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W),
        .FILL  (1'b0)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .ser_ready (ser_ready),
        .ser_valid (ser_valid),
        .ser_out   (ser_out),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [7:0] w);
        for (int i = 0; i < 8; i++) exp_q.push_back(w[i]);
        if (PAR_EN != 0) exp_q.push_back(^w);
    endtask

    // One cycle: compare the presented bit against the scoreboard head, pop on handshake.
    task automatic cyc(input logic r);
        ser_ready = r;
        if (ser_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL extra_bit observed=%0b expected=none", ser_out);
            end else begin
                check("ser_out", 32'(ser_out), 32'(exp_q[0]));
                if (r) void'(exp_q.pop_front());
            end
        end
        step();
    endtask

    // mode 0: always ready; 1: toggle 1,0,...; 2: ready except a 20-cycle stall
    task automatic drain(input int mode, input int exp_done_cyc);
        int   c;
        bit   got;
        logic r;
        c   = 1;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
            case (mode)
                0:       r = 1'b1;
                1:       r = (i % 2 == 0);
                default: r = !(i >= 3 && i < 23);
            endcase
            cyc(r);
            c++;
        end
        check("done_seen", 32'(got), 32'd1);
        if (got) begin
            check("done_ser_valid", 32'(ser_valid), 32'd0);
            check("done_busy", 32'(busy), 32'd1);
            check("queue_empty", 32'(exp_q.size()), 32'd0);
            check("done_latency", 32'(c), 32'(exp_done_cyc));
        end
    endtask

    task automatic after_done();
        step();
        check("done_single", 32'(done), 32'd0);
        check("idle_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic accept(input logic [7:0] w);
        check("pre_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        din      = w;
        push_word(w);
        step();
        in_valid = 1'b0;
        din      = 8'($urandom);
        check("post_busy", 32'(busy), 32'd1);
        check("post_in_ready", 32'(in_ready), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clr       = 1'b1;
        in_valid  = 1'b0;
        din       = 8'h00;
        ser_ready = 1'b0;
        step();
        step();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ser_valid", 32'(ser_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ser_out", 32'(ser_out), 32'd0);
        clr = 1'b0;
        step();
        check("idle_after_rst", 32'(in_ready), 32'd1);

        // Basic word, consumer always ready
        accept(8'hA5);
        drain(0, 9 + PAR_EN);
        after_done();

        // Consumer alternates ready
        accept(8'h01);
        drain(1, (PAR_EN != 0) ? 18 : 16);
        after_done();

        // in_valid held through the word with different din
        check("pre_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        din      = 8'hC3;
        push_word(8'hC3);
        step();
        din = 8'h5A;
        drain(0, 9 + PAR_EN);
        step();
        check("b2b_done_single", 32'(done), 32'd0);
        check("b2b_in_ready", 32'(in_ready), 32'd1);
        push_word(8'h5A);
        step();
        in_valid = 1'b0;
        check("b2b_busy", 32'(busy), 32'd1);
        drain(0, 9 + PAR_EN);
        after_done();

        // Reset mid-word discards the word without a done pulse
        accept(8'hFF);
        for (int i = 0; i < 4; i++) cyc(1'b1);
        clr       = 1'b1;
        ser_ready = 1'b1;
        step();
        clr = 1'b0;
        exp_q.delete();
        check("clr_in_ready", 32'(in_ready), 32'd1);
        check("clr_ser_valid", 32'(ser_valid), 32'd0);
        check("clr_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 6; i++) begin
            check("clr_no_done", 32'(done), 32'd0);
            step();
        end
        accept(8'h3C);
        drain(0, 9 + PAR_EN);
        after_done();

        // clr beats a simultaneous accept
        clr      = 1'b1;
        in_valid = 1'b1;
        din      = 8'hAA;
        step();
        clr      = 1'b0;
        in_valid = 1'b0;
        check("clr_acc_busy", 32'(busy), 32'd0);
        check("clr_acc_in_ready", 32'(in_ready), 32'd1);
        step();
        check("clr_acc_ser_valid", 32'(ser_valid), 32'd0);

        // Long stall mid-word
        accept(8'h96);
        drain(2, 29 + PAR_EN);
        after_done();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
